// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu memory subsystem: SRAM arbiter states and port ids.
package tinyalu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_PORT_MIF  = 1'b0,
    ARB_PORT_LOAD = 1'b1
  } arb_port_t;

  // One-hot grant vector for a port id.
  function automatic logic [1:0] arb_port_onehot(input arb_port_t port);
    return (port == ARB_PORT_LOAD) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// BUSY-cycle counter for the SRAM arbiter; flags expiry after TIMEOUT_CYCLES enabled cycles.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  // Counter value k means k+1 enabled cycles seen, so expiry lands on the last allowed cycle.
  assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Count enabled cycles, hold at expiry, restart on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the memory interface unit (port 0)
// and the preload/debug loader (port 1). All outputs are registered.
// Optional feature: define ARB_TIMEOUT_EN to abandon accesses after TIMEOUT_CYCLES BUSY cycles.
module sram_port_arbiter
  import tinyalu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned WDATA_W        = 16,
  parameter int unsigned RDATA_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               re0,
  input  logic               we0,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [WDATA_W-1:0] wdata0,
  output logic [RDATA_W-1:0] rdata0,
  output logic               resp0,
  output logic               err0,
  input  logic               re1,
  input  logic               we1,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [WDATA_W-1:0] wdata1,
  output logic [RDATA_W-1:0] rdata1,
  output logic               resp1,
  output logic               err1,
  output logic               sram_re,
  output logic               sram_we,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [WDATA_W-1:0] sram_wdata,
  input  logic [RDATA_W-1:0] sram_rdata,
  input  logic               sram_resp,
  output logic [1:0]         gnt,
  output logic               busy
);

  arb_state_t         state;
  arb_port_t          last_gnt;
  logic               req0, req1;
  arb_port_t          pick;
  logic               pick_we;
  logic [ADDR_W-1:0]  pick_addr;
  logic [WDATA_W-1:0] pick_wdata;
  logic               timed_out;

`ifdef ARB_TIMEOUT_EN
  logic wd_expired;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != BUSY),
    .enable (state == BUSY),
    .expired(wd_expired)
  );

  assign timed_out = wd_expired;
`else
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err0           = 1'b0;
  assign err1           = 1'b0;
`endif

  // Pick the winner among current requesters; on contention the port not served last wins.
  always_comb begin
    req0 = re0 | we0;
    req1 = re1 | we1;
    pick = ARB_PORT_MIF;
    if (req0 && req1) begin
      pick = (last_gnt == ARB_PORT_MIF) ? ARB_PORT_LOAD : ARB_PORT_MIF;
    end else if (req1) begin
      pick = ARB_PORT_LOAD;
    end
    // A port asserting both re and we is treated as a write.
    pick_we    = (pick == ARB_PORT_LOAD) ? we1 : we0;
    pick_addr  = (pick == ARB_PORT_LOAD) ? addr1 : addr0;
    pick_wdata = (pick == ARB_PORT_LOAD) ? wdata1 : wdata0;
  end

  // Access FSM with registered SRAM strobes, grant and per-port responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_gnt   <= ARB_PORT_LOAD;
      sram_re    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      gnt        <= 2'b00;
      busy       <= 1'b0;
      resp0      <= 1'b0;
      resp1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
`ifdef ARB_TIMEOUT_EN
      err0       <= 1'b0;
      err1       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= BUSY;
            last_gnt   <= pick;
            gnt        <= arb_port_onehot(pick);
            busy       <= 1'b1;
            sram_we    <= pick_we;
            sram_re    <= ~pick_we;
            sram_addr  <= pick_addr;
            sram_wdata <= pick_wdata;
          end
        end
        BUSY: begin
          // A response in the expiry cycle still completes normally.
          if (sram_resp || timed_out) begin
            state      <= DONE;
            sram_re    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            resp0      <= gnt[0];
            resp1      <= gnt[1];
            rdata0     <= (gnt[0] && sram_resp && !sram_we) ? sram_rdata : '0;
            rdata1     <= (gnt[1] && sram_resp && !sram_we) ? sram_rdata : '0;
`ifdef ARB_TIMEOUT_EN
            err0       <= gnt[0] && !sram_resp;
            err1       <= gnt[1] && !sram_resp;
`endif
          end
        end
        DONE: begin
          state  <= IDLE;
          gnt    <= 2'b00;
          busy   <= 1'b0;
          resp0  <= 1'b0;
          resp1  <= 1'b0;
          rdata0 <= '0;
          rdata1 <= '0;
`ifdef ARB_TIMEOUT_EN
          err0   <= 1'b0;
          err1   <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
